parking_timer_ctrl: RTL and testbench

Per-slot parking-duration controller for the parking system. Tracks occupancy and elapsed seconds for each bay, saturating at the 11-bit time limit. Scheduler rotates the seven-segment display among active bays and emits one 11-bit seconds value plus slot index per cycle to the downstream mm:ss seven-segment decoder.

---
 rtl/parking_pkg.sv | 25 ++
 rtl/parking_timer_ctrl_if.sv | 36 +++
 rtl/sec_tick_gen.sv | 30 +++
 rtl/parking_timer_ctrl.sv | 158 +++++++++++++++
 tb/tb_parking_timer_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking-duration controller.
//   slot_state_t : per-bay lifecycle (FREE -> OCCUPIED -> DONE -> FREE)
//   slot_t       : state + elapsed seconds of one bay, as seen by the display
//   cnt_w()      : counter width for a modulus n (at least 1 bit)
package parking_pkg;

  typedef enum logic [1:0] {
    FREE     = 2'd0,
    OCCUPIED = 2'd1,
    DONE     = 2'd2
  } slot_state_t;

  localparam int                TIME_W   = 11;
  localparam logic [TIME_W-1:0] TIME_MAX = 11'd2047;

  typedef struct packed {
    slot_state_t       st;
    logic [TIME_W-1:0] tm;
  } slot_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/parking_timer_ctrl_if.sv
// Bay sensor / display bundle of the parking-duration controller.
//   car_in, car_out : one-cycle arrival / departure pulses per bay
//   occupied, done  : per-bay state flags
//   full            : no bay is FREE
//   disp_time/slot  : seconds and index of the displayed bay
//   disp_valid      : displayed bay is not FREE
//   sec_tick        : 1 Hz one-cycle strobe
// master = sensor/display side, slave = controller.
interface parking_timer_ctrl_if #(
  parameter int SLOTS = 4
);
  import parking_pkg::*;

  localparam int SLOT_W = cnt_w(SLOTS);

  logic [SLOTS-1:0]  car_in;
  logic [SLOTS-1:0]  car_out;
  logic [SLOTS-1:0]  occupied;
  logic [SLOTS-1:0]  done;
  logic              full;
  logic [TIME_W-1:0] disp_time;
  logic [SLOT_W-1:0] disp_slot;
  logic              disp_valid;
  logic              sec_tick;

  modport master (
    output car_in, car_out,
    input  occupied, done, full, disp_time, disp_slot, disp_valid, sec_tick
  );

  modport slave (
    input  car_in, car_out,
    output occupied, done, full, disp_time, disp_slot, disp_valid, sec_tick
  );

endinterface

// File: rtl/sec_tick_gen.sv
// 1 Hz prescaler: counts 0..CLK_HZ-1 and strobes sec_tick for one cycle per
// wrap.
//   clk, reset : system clock, synchronous active-high reset
//   sec_tick   : registered strobe, high in the cycle after the terminal
//                count, so the first strobe after reset lands CLK_HZ cycles
//                after the last reset edge
module sec_tick_gen import parking_pkg::*; #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic sec_tick
);

  localparam int             CNT_W = cnt_w(CLK_HZ);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      sec_tick <= 1'b0;
    end else begin
      sec_tick <= (cnt == LAST);
      cnt      <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/parking_timer_ctrl.sv
// Per-bay parking-duration controller with rotating display scheduler.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : parking_timer_ctrl_if.slave (sensor pulses in; bay flags,
//                full, display value/index/valid and sec_tick out)
// Each bay runs FREE -> OCCUPIED -> DONE -> FREE, counting whole seconds
// while occupied (saturating at TIME_MAX) and holding its final time for
// HOLD_S seconds after departure. The scheduler shows one non-FREE bay at a
// time, moving on every ROTATE_S seconds or as soon as the shown bay frees.
module parking_timer_ctrl import parking_pkg::*; #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SLOTS    = 4,
  parameter int ROTATE_S = 3,
  parameter int HOLD_S   = 5
) (
  input  logic              clk,
  input  logic              reset,
  parking_timer_ctrl_if.slave bus
);

  localparam int SLOT_W = cnt_w(SLOTS);
  localparam int HOLD_W = cnt_w(HOLD_S);
  localparam int ROT_W  = cnt_w(ROTATE_S);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_S - 1);
  localparam logic [ROT_W-1:0]  ROT_LAST  = ROT_W'(ROTATE_S - 1);

  logic tick;

  sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .sec_tick (tick)
  );

  assign bus.sec_tick = tick;

  // ---------------------------------------------------------------- bays
  slot_t            slot [SLOTS];
  logic [SLOTS-1:0] occ, dn, active;

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    slot_state_t       st_q;
    logic [TIME_W-1:0] tm_q;
    logic [HOLD_W-1:0] hold_q;
    logic              occ_q, done_q;

    // car_in only matters in FREE and car_out only in OCCUPIED, so a
    // simultaneous pair resolves to whichever is legal for the state.
    // A departure beats a same-cycle tick: the time freezes unincremented.
    always_ff @(posedge clk) begin
      if (reset) begin
        st_q   <= FREE;
        tm_q   <= '0;
        hold_q <= '0;
        occ_q  <= 1'b0;
        done_q <= 1'b0;
      end else begin
        case (st_q)
          FREE: if (bus.car_in[i]) begin
            st_q  <= OCCUPIED;
            tm_q  <= '0;
            occ_q <= 1'b1;
          end
          OCCUPIED: begin
            if (bus.car_out[i]) begin
              st_q   <= DONE;
              hold_q <= '0;
              occ_q  <= 1'b0;
              done_q <= 1'b1;
            end else if (tick && tm_q != TIME_MAX) begin
              tm_q <= tm_q + 1'b1;
            end
          end
          DONE: if (tick) begin
            if (hold_q == HOLD_LAST) begin
              st_q   <= FREE;
              done_q <= 1'b0;
            end else begin
              hold_q <= hold_q + 1'b1;
            end
          end
          default: begin
            st_q   <= FREE;
            occ_q  <= 1'b0;
            done_q <= 1'b0;
          end
        endcase
      end
    end

    assign slot[i]   = '{st: st_q, tm: tm_q};
    assign occ[i]    = occ_q;
    assign dn[i]     = done_q;
    assign active[i] = (slot[i].st != FREE);
  end

  assign bus.occupied = occ;
  assign bus.done     = dn;
  assign bus.full     = &(occ | dn);

  // ------------------------------------------------------------ display
  // Round-robin search starting just after cur and wrapping back to cur
  // itself; with nothing active the index simply holds.
  function automatic logic [SLOT_W-1:0] rr_next(input logic [SLOT_W-1:0] cur,
                                                input logic [SLOTS-1:0]  act);
    logic [SLOT_W-1:0] r;
    r = cur;
    // Scan farthest-first so the nearest active bay is the last write.
    for (int k = SLOTS; k >= 1; k--) begin
      logic [SLOT_W-1:0] j;
      j = SLOT_W'((int'(cur) + k) % SLOTS);
      if (act[j]) r = j;
    end
    return r;
  endfunction

  logic [SLOT_W-1:0] cur_q, sel;
  logic [ROT_W-1:0]  rot_q, rot_d;
  logic [TIME_W-1:0] dtime_q;
  logic              dvalid_q;

  // A non-active current bay (just freed, or idle display) is re-searched
  // every cycle, which also picks up the first arrival on an idle display.
  always_comb begin
    sel   = cur_q;
    rot_d = rot_q;
    if (!active[cur_q]) begin
      sel   = rr_next(cur_q, active);
      rot_d = '0;
    end else if (tick) begin
      if (rot_q == ROT_LAST) begin
        sel   = rr_next(cur_q, active);
        rot_d = '0;
      end else begin
        rot_d = rot_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q    <= '0;
      rot_q    <= '0;
      dtime_q  <= '0;
      dvalid_q <= 1'b0;
    end else begin
      cur_q    <= sel;
      rot_q    <= rot_d;
      dvalid_q <= active[sel];
      dtime_q  <= active[sel] ? slot[sel].tm : '0;
    end
  end

  assign bus.disp_slot  = cur_q;
  assign bus.disp_time  = dtime_q;
  assign bus.disp_valid = dvalid_q;

endmodule

// File: tb/tb_parking_timer_ctrl.sv
// Scoreboard bench for parking_timer_ctrl (CLK_HZ=4, SLOTS=4, ROTATE_S=3,
// HOLD_S=5). Stimulus pushes {cycle, field, value} expectations; a monitor
// on the falling edge compares the DUT field when the cycle counter matches.
module tb_parking_timer_ctrl;

  typedef enum {K_OCC, K_DONE, K_FULL, K_TIME, K_SLOT, K_VALID, K_TICK} kind_e;
  typedef struct {
    int          at;
    kind_e       kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic clk    = 1'b0;
  logic reset  = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  parking_timer_ctrl_if #(.SLOTS(4)) bus ();

  parking_timer_ctrl #(
    .CLK_HZ(4), .SLOTS(4), .ROTATE_S(3), .HOLD_S(5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] actual(input kind_e k);
    case (k)
      K_OCC:   return 32'(bus.occupied);
      K_DONE:  return 32'(bus.done);
      K_FULL:  return 32'(bus.full);
      K_TIME:  return 32'(bus.disp_time);
      K_SLOT:  return 32'(bus.disp_slot);
      K_VALID: return 32'(bus.disp_valid);
      K_TICK:  return 32'(bus.sec_tick);
      default: return 32'hffff_ffff;
    endcase
  endfunction

  // monitor
  initial begin
    logic [31:0] a;
    forever begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].at <= cyc) begin
          a = actual(sb[i].kind);
          checks++;
          if (sb[i].at != cyc || a !== sb[i].val) begin
            errors++;
            $display("FAIL %s @cycle %0d (due %0d): got %0d, want %0d",
                     sb[i].name, cyc, sb[i].at, a, sb[i].val);
          end
          sb.delete(i);
        end
      end
    end
  end

  task automatic ex(input int at, input kind_e k, input logic [31:0] v, input string nm);
    exp_t e;
    e.at = at; e.kind = k; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic pulse(input logic [3:0] ci, input logic [3:0] co);
    bus.car_in  = ci;
    bus.car_out = co;
    @(negedge clk);
    bus.car_in  = '0;
    bus.car_out = '0;
  endtask

  task automatic wait_until(input int at);
    while (cyc < at) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Land on the falling edge of a cycle in which sec_tick is high.
  task automatic sync_tick(output int t);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.sec_tick && n < 10);
    if (!bus.sec_tick) begin
      checks++;
      errors++;
      $display("FAIL sync_tick: no sec_tick within %0d cycles", n);
    end
    t = cyc;
  endtask

  initial begin
    int t;
    bus.car_in  = '0;
    bus.car_out = '0;

    // reset values
    @(negedge clk);
    t = cyc;
    ex(t+1, K_OCC, 0, "rst_occ");    ex(t+1, K_DONE, 0, "rst_done");
    ex(t+1, K_FULL, 0, "rst_full");  ex(t+1, K_TIME, 0, "rst_time");
    ex(t+1, K_SLOT, 0, "rst_slot");  ex(t+1, K_VALID, 0, "rst_valid");
    ex(t+1, K_TICK, 0, "rst_tick");
    @(negedge clk);
    reset = 1'b0;

    // basic count: bay 1, 10 ticks
    do_reset(); sync_tick(t);
    ex(t+1,  K_OCC,   4'b0010, "s1_occ");
    ex(t+1,  K_VALID, 0,       "s1_valid_lag");
    ex(t+2,  K_VALID, 1,       "s1_valid");
    ex(t+2,  K_SLOT,  1,       "s1_slot_first");
    ex(t+41, K_TIME,  9,       "s1_time9");
    ex(t+42, K_TIME,  10,      "s1_time10");
    ex(t+42, K_SLOT,  1,       "s1_slot");
    ex(t+42, K_OCC,   4'b0010, "s1_occ_end");
    pulse(4'b0010, 4'b0000);
    wait_until(t+43);

    // saturation: bay 0 for 2050 ticks
    do_reset(); sync_tick(t);
    ex(t+8186, K_TIME, 2046, "s2_time2046");
    ex(t+8190, K_TIME, 2047, "s2_time2047");
    ex(t+8202, K_TIME, 2047, "s2_sat_2050");
    ex(t+8210, K_TIME, 2047, "s2_sat_hold");
    pulse(4'b0001, 4'b0000);
    wait_until(t+8211);

    // departure with same-cycle tick, then hold expiry
    do_reset(); sync_tick(t);
    ex(t+30, K_TIME,  7,       "s3_time7");
    ex(t+33, K_DONE,  4'b0100, "s3_done");
    ex(t+33, K_OCC,   0,       "s3_occ_clr");
    ex(t+34, K_TIME,  7,       "s3_frozen");
    ex(t+50, K_TIME,  7,       "s3_hold_time");
    ex(t+50, K_VALID, 1,       "s3_hold_valid");
    ex(t+52, K_DONE,  4'b0100, "s3_done_last");
    ex(t+53, K_DONE,  0,       "s3_freed");
    ex(t+53, K_VALID, 1,       "s3_valid_lag");
    ex(t+54, K_VALID, 0,       "s3_valid_idle");
    ex(t+54, K_TIME,  0,       "s3_time_idle");
    ex(t+54, K_SLOT,  2,       "s3_slot_hold");
    pulse(4'b0100, 4'b0000);
    wait_until(t+32);
    pulse(4'b0000, 4'b0100);
    wait_until(t+55);

    // rotation between bays 0 and 3
    do_reset(); sync_tick(t);
    ex(t+12, K_SLOT, 0,       "s4_slot0a");
    ex(t+13, K_SLOT, 3,       "s4_slot3");
    ex(t+13, K_TIME, 2,       "s4_time3");
    ex(t+24, K_SLOT, 3,       "s4_slot3_end");
    ex(t+25, K_SLOT, 0,       "s4_slot0b");
    ex(t+36, K_SLOT, 0,       "s4_slot0c");
    ex(t+37, K_SLOT, 3,       "s4_slot3_done");
    ex(t+44, K_DONE, 4'b1000, "s4_done3");
    ex(t+45, K_SLOT, 3,       "s4_slot3_last");
    ex(t+46, K_SLOT, 0,       "s4_return0");
    ex(t+46, K_DONE, 0,       "s4_freed3");
    ex(t+60, K_SLOT, 0,       "s4_stay0");
    ex(t+60, K_VALID, 1,      "s4_valid");
    pulse(4'b1001, 4'b0000);
    wait_until(t+26);
    pulse(4'b0000, 4'b1000);
    wait_until(t+61);

    // conflicts and full
    do_reset(); sync_tick(t);
    ex(t+11, K_OCC,  4'b0011, "s5_in_out_free");
    ex(t+11, K_DONE, 0,       "s5_no_done");
    ex(t+12, K_TIME, 2,       "s5_in_ignored");
    ex(t+12, K_SLOT, 0,       "s5_slot");
    ex(t+14, K_FULL, 0,       "s5_not_full");
    ex(t+15, K_OCC,  4'b1111, "s5_all_occ");
    ex(t+15, K_FULL, 1,       "s5_full");
    ex(t+19, K_DONE, 4'b0100, "s5_done2");
    ex(t+19, K_FULL, 1,       "s5_full_done");
    ex(t+36, K_FULL, 1,       "s5_full_hold");
    ex(t+37, K_FULL, 0,       "s5_full_clr");
    ex(t+37, K_DONE, 0,       "s5_done_clr");
    pulse(4'b0001, 4'b0000);
    wait_until(t+10);
    pulse(4'b0011, 4'b0010);
    wait_until(t+14);
    pulse(4'b1100, 4'b0000);
    wait_until(t+18);
    pulse(4'b0000, 4'b0100);
    wait_until(t+38);

    // reset mid-run
    do_reset(); sync_tick(t);
    ex(t+10, K_OCC,   4'b1110, "s6_pre_occ");
    ex(t+10, K_SLOT,  1,       "s6_pre_slot");
    ex(t+10, K_TIME,  2,       "s6_pre_time");
    ex(t+11, K_OCC,   0,       "s6_occ");
    ex(t+11, K_DONE,  0,       "s6_done");
    ex(t+11, K_FULL,  0,       "s6_full");
    ex(t+11, K_TIME,  0,       "s6_time");
    ex(t+11, K_SLOT,  0,       "s6_slot");
    ex(t+11, K_VALID, 0,       "s6_valid");
    ex(t+11, K_TICK,  0,       "s6_tick");
    ex(t+12, K_TICK,  0,       "s6_tick_old_phase");
    ex(t+14, K_TICK,  0,       "s6_tick_early");
    ex(t+15, K_TICK,  1,       "s6_tick_first");
    ex(t+15, K_OCC,   0,       "s6_occ_after");
    pulse(4'b1110, 4'b0000);
    wait_until(t+10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_until(t+16);

    // drain
    for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations never compared", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
